// File: rtl/md_unit_9.sv
// Iterative multiply/divide unit with HI/LO result registers (shift-add multiply, restoring divide).
// Optional build macro MD_UNIT_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module md_unit_9 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   m;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] p;        // {partial product | remainder, multiplier | quotient}
    logic               neg_q, neg_r, is_div, dz;

    logic               accept, is_mul_op, is_div_op, signed_op, b_zero, last;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, mul_raw, mul_res;
    logic [WIDTH-1:0]   quot, rem;

    assign accept    = start && (state == IDLE);
    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign b_zero    = (B == '0);
    assign a_abs     = (signed_op && A[WIDTH-1]) ? -A : A;
    assign b_abs     = (signed_op && B[WIDTH-1]) ? -B : B;
    assign last      = (cnt == CW'(WIDTH - 1));

    // One iteration step of each algorithm plus the sign fix-up applied in FIX.
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        mul_next  = {mul_sum, p[WIDTH-1:1]};
        div_trial = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, m};
        div_next  = div_trial[WIDTH] ? {p[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
`ifdef MD_UNIT_FAST_MUL_EN
        mul_raw   = {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, p[WIDTH-1:0]};
`else
        mul_raw   = p;
`endif
        mul_res   = neg_q ? -mul_raw : mul_raw;
        quot      = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem       = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (accept && is_mul_op) begin
`ifdef MD_UNIT_FAST_MUL_EN
                    state_next = FIX;
`else
                    state_next = MUL;
`endif
                end else if (accept && is_div_op) begin
                    state_next = b_zero ? FIX : DIV;
                end
            end
            MUL:     if (last) state_next = FIX;
            DIV:     if (last) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            m        <= '0;
            p        <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        if (is_mul_op) begin
                            m      <= a_abs;
                            p      <= {{WIDTH{1'b0}}, b_abs};
                            neg_q  <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                            is_div <= 1'b0;
                            dz     <= 1'b0;
                        end else if (is_div_op) begin
                            // On divide-by-zero the raw dividend is kept so FIX can return it in hi.
                            m      <= b_abs;
                            p      <= {{WIDTH{1'b0}}, b_zero ? A : a_abs};
                            neg_q  <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r  <= signed_op && A[WIDTH-1];
                            is_div <= 1'b1;
                            dz     <= b_zero;
                        end else if (op == OP_MTHI) begin
                            hi <= A;
                        end else if (op == OP_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                MUL: begin
                    p   <= mul_next;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    p   <= div_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (is_div) begin
                        div_zero <= dz;
                        if (dz) begin
                            hi <= p[WIDTH-1:0];
                            lo <= '1;
                        end else begin
                            hi <= rem;
                            lo <= quot;
                        end
                    end else begin
                        {hi, lo} <= mul_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_9.sv
// Directed self-checking bench for md_unit_9 (WIDTH=32); expected values are hand-computed.
// Honours MD_UNIT_FAST_MUL_EN for the expected multiply busy length.
module tb_md_unit_9;

    localparam int W = 32;
`ifdef MD_UNIT_FAST_MUL_EN
    localparam int MUL_BUSY = 1;
    localparam int SECOND_OFF = 0;
`else
    localparam int MUL_BUSY = W + 1;
    localparam int SECOND_OFF = 9;
`endif
    localparam int DIV_BUSY = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    md_unit_9 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, count busy cycles, and check results plus the done pulse.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int exp_busy,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        logic [W-1:0] old_hi, old_lo;
        int nb;
        old_hi = hi;
        old_lo = lo;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_hold"}, {hi, lo}, {old_hi, old_lo});
        nb = 0;
        while (busy && nb < 200) begin
            nb++;
            @(posedge clk); #1;
        end
        check({tag, "_busy"}, 64'(nb), 64'(exp_busy));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk); #1;
        check({tag, "_done_low"}, 64'(done), 64'd0);
    endtask

    initial begin
        int nb, nd;
        #12;
        check("reset_hi_lo", {hi, lo}, 64'd0);
        check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("mult",  3'd0, 32'hFFFF_FFFE, 32'h0000_0003, MUL_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, MUL_BUSY, 32'h0000_0002, 32'hFFFF_FFFA);
        do_op("div_n7_2",  3'd2, 32'hFFFF_FFF9, 32'd2, DIV_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_7_n2",  3'd2, 32'd7, 32'hFFFF_FFFE, DIV_BUSY, 32'd1, 32'hFFFF_FFFD);
        do_op("divu_7_2",  3'd3, 32'd7, 32'd2, DIV_BUSY, 32'd1, 32'd3);
        check("divu_dz_clear", 64'(div_zero), 64'd0);

        do_op("divu_by0", 3'd3, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 32'hFFFF_FFFF);
        check("dz_set", 64'(div_zero), 64'd1);
        do_op("mult_keep_dz", 3'd1, 32'd6, 32'd7, MUL_BUSY, 32'd0, 32'd42);
        check("dz_kept_by_mul", 64'(div_zero), 64'd1);
        do_op("div_10_3", 3'd2, 32'd10, 32'd3, DIV_BUSY, 32'd1, 32'd3);
        check("dz_cleared", 64'(div_zero), 64'd0);

        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_BUSY, 32'd0, 32'h8000_0000);

        // MTHI / MTLO write on the accepting edge with no busy and no done
        @(negedge clk); start = 1'b1; op = 3'd4; a = 32'hCAFE_F00D;
        @(posedge clk); #1; start = 1'b0;
        check("mthi_hi", 64'(hi), 64'hCAFE_F00D);
        check("mthi_lo_kept", 64'(lo), 64'h8000_0000);
        check("mthi_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk); start = 1'b1; op = 3'd5; a = 32'h0BAD_BEEF;
        @(posedge clk); #1; start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h0BAD_BEEF);
        check("mtlo_hi_kept", 64'(hi), 64'hCAFE_F00D);
        @(posedge clk); #1;
        check("mt_no_done", {62'd0, busy, done}, 64'd0);

        // reserved opcode: nothing changes
        @(negedge clk); start = 1'b1; op = 3'd6; a = 32'h1111_1111; b = 32'd1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check("reserved_op", {hi, lo}, {32'hCAFE_F00D, 32'h0BAD_BEEF});
        check("reserved_busy", 64'(busy), 64'd0);

        // start while busy is ignored
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        nb = 0; nd = 0;
        for (int c = 0; c < W + 8; c++) begin
            nb += int'(busy);
            nd += int'(done);
            @(negedge clk);
            if (c == SECOND_OFF) begin
                start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("sb_busy", 64'(nb), 64'(MUL_BUSY));
        check("sb_dones", 64'(nd), 64'd1);
        check("sb_result", {hi, lo}, {32'd0, 32'd15});

        // asynchronous reset aborts a divide in progress (div_zero set first so it is seen clearing)
        do_op("divu_by0_b", 3'd3, 32'h0000_00AB, 32'd0, 1, 32'h0000_00AB, 32'hFFFF_FFFF);
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        check("arst_hi_lo", {hi, lo}, 64'd0);
        check("arst_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_aborted", {30'd0, busy, done, hi}, 64'd0);

        do_op("divu_after_rst", 3'd3, 32'd100, 32'd7, DIV_BUSY, 32'd2, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
